regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 17 +
 rtl/wb_skid_slot.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DATA_W      : register data width
//   REG_ADDR_W  : register index width
//   NUM_REGS    : number of architectural registers
//   arb_state_e : round-robin priority state (PRI_A / PRI_B)
package regfile_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_skid_slot.sv
// One-entry holding slot for a writeback requester.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready_c : requester handshake (ready is combinational)
//   in_reg, in_data     : destination index and data offered by requester
//   free                : slot contents leave this cycle (granted or dropped)
//   full                : slot holds an entry
//   slot_reg, slot_data : held destination index and data
module wb_skid_slot #(
    parameter int unsigned DATA_W     = regfile_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready_c,
    input  logic [REG_ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  free,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] slot_reg,
    output logic [DATA_W-1:0]     slot_data
);

    logic                  full_q, full_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     data_q, data_d;

    // Ready is held low while reset is asserted so nothing is accepted then.
    always_comb begin
        in_ready_c = rst_n & (~full_q | free);
        full_d     = full_q;
        reg_d      = reg_q;
        data_d     = data_q;
        if (free) begin
            full_d = 1'b0;
        end
        if (in_valid && in_ready_c) begin
            full_d = 1'b1;
            reg_d  = in_reg;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign full      = full_q;
    assign slot_reg  = reg_q;
    assign slot_data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto the single register-file
// write port and tracks registers with pending, uncommitted writes.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   a_valid/a_ready, a_reg/a_data: ALU writeback request
//   b_valid/b_ready, b_reg/b_data: load writeback request
//   wr_en/wr_reg/wr_data         : register-file write port (combinational)
//   alloc_valid/alloc_reg        : issue marks a destination pending
//   rd_reg1/rd_reg2              : source indices being read
//   rd_busy1/rd_busy2            : source has a pending write
//   byp_hit1/byp_hit2/byp_data   : writeback bypass (only with WB_BYPASS_EN)
// Optional feature macro: WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::arb_state_e;
    import regfile_pkg::PRI_A;
    import regfile_pkg::PRI_B;
#(
    parameter int unsigned DATA_W     = regfile_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0]     wr_data,
    input  logic                  alloc_valid,
    input  logic [REG_ADDR_W-1:0] alloc_reg,
    input  logic [REG_ADDR_W-1:0] rd_reg1,
    input  logic [REG_ADDR_W-1:0] rd_reg2,
`ifdef WB_BYPASS_EN
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_W-1:0]     byp_data,
`endif
    output logic                  rd_busy1,
    output logic                  rd_busy2
);

    localparam int unsigned NUM_REGS = (REG_ADDR_W == regfile_pkg::REG_ADDR_W)
                                     ? regfile_pkg::NUM_REGS : (1 << REG_ADDR_W);

    logic                  a_full, b_full;
    logic [REG_ADDR_W-1:0] a_slot_reg, b_slot_reg;
    logic [DATA_W-1:0]     a_slot_data, b_slot_data;
    logic                  a_free_c, b_free_c;
    logic                  a_live_c, b_live_c;
    logic                  grant_a_c, grant_b_c;
    logic                  other_same_c;

    arb_state_e            state_q, state_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    // Set when B's held entry was accepted strictly before A's held entry.
    logic                  b_older_q, b_older_d;

    wb_skid_slot #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_slot_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (a_valid),
        .in_ready_c (a_ready),
        .in_reg     (a_reg),
        .in_data    (a_data),
        .free       (a_free_c),
        .full       (a_full),
        .slot_reg   (a_slot_reg),
        .slot_data  (a_slot_data)
    );

    wb_skid_slot #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_slot_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_valid),
        .in_ready_c (b_ready),
        .in_reg     (b_reg),
        .in_data    (b_data),
        .free       (b_free_c),
        .full       (b_full),
        .slot_reg   (b_slot_reg),
        .slot_data  (b_slot_data)
    );

    // Grant selection, priority FSM next state and write port drive.
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_reg    = '0;
        wr_data   = '0;

        // Register 0 entries are discarded and never compete for the port.
        a_live_c = a_full & (a_slot_reg != '0);
        b_live_c = b_full & (b_slot_reg != '0);

        if (a_live_c && b_live_c) begin
            if (a_slot_reg == b_slot_reg) begin
                // Same destination: preserve acceptance order.
                grant_b_c = b_older_q;
                grant_a_c = ~b_older_q;
            end else if (state_q == PRI_A) begin
                grant_a_c = 1'b1;
            end else begin
                grant_b_c = 1'b1;
            end
        end else begin
            grant_a_c = a_live_c;
            grant_b_c = b_live_c;
        end

        if (grant_a_c) begin
            state_d = PRI_B;
            wr_en   = 1'b1;
            wr_reg  = a_slot_reg;
            wr_data = a_slot_data;
        end else if (grant_b_c) begin
            state_d = PRI_A;
            wr_en   = 1'b1;
            wr_reg  = b_slot_reg;
            wr_data = b_slot_data;
        end

        a_free_c = grant_a_c | (a_full & (a_slot_reg == '0));
        b_free_c = grant_b_c | (b_full & (b_slot_reg == '0));
    end

    // Acceptance-order tracking and pending-write scoreboard.
    always_comb begin
        b_older_d    = b_older_q;
        pending_d    = pending_q;
        other_same_c = 1'b0;

        if (b_valid && b_ready) begin
            b_older_d = 1'b0;
        end else if (a_valid && a_ready) begin
            b_older_d = b_full & ~b_free_c;
        end

        if (wr_en) begin
            other_same_c = grant_a_c ? (b_full & (b_slot_reg == a_slot_reg))
                                     : (a_full & (a_slot_reg == b_slot_reg));
            if (!other_same_c) begin
                pending_d[wr_reg] = 1'b0;
            end
        end
        // Allocation wins over a same-edge commit of the same register.
        if (alloc_valid && (alloc_reg != '0)) begin
            pending_d[alloc_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PRI_A;
            pending_q <= '0;
            b_older_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            b_older_q <= b_older_d;
        end
    end

`ifdef WB_BYPASS_EN
    // A source being written this cycle is forwarded instead of stalling.
    always_comb begin
        byp_hit1 = wr_en & (wr_reg == rd_reg1);
        byp_hit2 = wr_en & (wr_reg == rd_reg2);
        byp_data = wr_data;
        rd_busy1 = pending_q[rd_reg1] & ~byp_hit1;
        rd_busy2 = pending_q[rd_reg2] & ~byp_hit2;
    end
`else
    always_comb begin
        rd_busy1 = pending_q[rd_reg1];
        rd_busy2 = pending_q[rd_reg2];
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a
// transaction-level model (age stamps, priority flag, pending array).
module tb_regfile_wb_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_reg, b_reg, wr_reg, alloc_reg, rd_reg1, rd_reg2;
    logic [DW-1:0] a_data, b_data, wr_data;
    logic          wr_en, alloc_valid, rd_busy1, rd_busy2;
`ifdef WB_BYPASS_EN
    logic          byp_hit1, byp_hit2;
    logic [DW-1:0] byp_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .alloc_valid (alloc_valid),
        .alloc_reg   (alloc_reg),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
`ifdef WB_BYPASS_EN
        .byp_hit1    (byp_hit1),
        .byp_hit2    (byp_hit2),
        .byp_data    (byp_data),
`endif
        .rd_busy1    (rd_busy1),
        .rd_busy2    (rd_busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            ma_full, mb_full;
    logic [AW-1:0] ma_reg, mb_reg;
    logic [DW-1:0] ma_data, mb_data;
    int            ma_seq, mb_seq;
    bit            m_prio_a;
    bit            m_pend [NR];
    logic [DW-1:0] m_rf   [NR];
    int            m_cyc;

    task automatic model_reset();
        ma_full  = 0;
        mb_full  = 0;
        m_prio_a = 1;
        for (int i = 0; i < NR; i++) m_pend[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        m_cyc = 0;
        model_reset();
    end

    // Compare every cycle on the falling edge, then advance the model.
    always @(negedge clk) begin : cmp_proc
        int            g;
        bit            a_live, b_live, a_free, b_free, ea_rdy, eb_rdy;
        logic [AW-1:0] ereg;
        logic [DW-1:0] edata;
        bit            eb1, eb2, other_same;
        if (!rst_n) begin
            check("rst_wr_en", wr_en, 0);
            check("rst_wr_reg", wr_reg, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_a_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_busy1", rd_busy1, 0);
            check("rst_busy2", rd_busy2, 0);
            model_reset();
        end else begin
            a_live = ma_full && (ma_reg != 0);
            b_live = mb_full && (mb_reg != 0);
            g = 0;
            if (a_live && b_live) begin
                if (ma_reg == mb_reg) g = (ma_seq <= mb_seq) ? 1 : 2;
                else                  g = m_prio_a ? 1 : 2;
            end else if (a_live) g = 1;
            else if (b_live)     g = 2;
            ereg  = (g == 1) ? ma_reg  : (g == 2) ? mb_reg  : '0;
            edata = (g == 1) ? ma_data : (g == 2) ? mb_data : '0;
            a_free = ma_full && (g == 1 || ma_reg == 0);
            b_free = mb_full && (g == 2 || mb_reg == 0);
            ea_rdy = !ma_full || a_free;
            eb_rdy = !mb_full || b_free;
            eb1 = m_pend[rd_reg1];
            eb2 = m_pend[rd_reg2];
`ifdef WB_BYPASS_EN
            check("byp_hit1", byp_hit1, (g != 0) && (ereg == rd_reg1));
            check("byp_hit2", byp_hit2, (g != 0) && (ereg == rd_reg2));
            if (g != 0) check("byp_data", byp_data, edata);
            if (g != 0 && ereg == rd_reg1) eb1 = 0;
            if (g != 0 && ereg == rd_reg2) eb2 = 0;
`endif
            check("wr_en", wr_en, g != 0);
            check("wr_reg", wr_reg, ereg);
            check("wr_data", wr_data, edata);
            check("a_ready", a_ready, ea_rdy);
            check("b_ready", b_ready, eb_rdy);
            check("rd_busy1", rd_busy1, eb1);
            check("rd_busy2", rd_busy2, eb2);

            if (g != 0) begin
                m_rf[ereg] = edata;
                other_same = (g == 1) ? (mb_full && mb_reg == ereg) : (ma_full && ma_reg == ereg);
                if (!other_same) m_pend[ereg] = 0;
                m_prio_a = (g == 2);
            end
            if (alloc_valid && alloc_reg != 0) m_pend[alloc_reg] = 1;
            m_cyc++;
            if (a_free) ma_full = 0;
            if (b_free) mb_full = 0;
            if (a_valid && ea_rdy) begin
                ma_full = 1; ma_reg = a_reg; ma_data = a_data; ma_seq = m_cyc;
            end
            if (b_valid && eb_rdy) begin
                mb_full = 1; mb_reg = b_reg; mb_data = b_data; mb_seq = m_cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; alloc_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
        alloc_reg = '0; rd_reg1 = '0; rd_reg2 = '0;
        #2;
        check("init_wr_en", wr_en, 0);
        check("init_a_ready", a_ready, 0);
        check("init_b_ready", b_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        check("post_rst_a_ready", a_ready, 1);
        check("post_rst_b_ready", b_ready, 1);

        // A only, r3
        a_valid = 1; a_reg = 4'd3; a_data = 16'h1234;
        step(); idle_inputs();
        check("a_only_wr_en", wr_en, 1);
        check("a_only_wr_reg", wr_reg, 3);
        check("a_only_wr_data", wr_data, 16'h1234);
        check("a_only_a_ready", a_ready, 1);
        step();
        check("a_only_done", wr_en, 0);

        // Both after reset, different registers
        do_reset();
        a_valid = 1; a_reg = 4'd5; a_data = 16'hAAAA;
        b_valid = 1; b_reg = 4'd6; b_data = 16'h5555;
        step(); idle_inputs();
        check("ab_c1_reg", wr_reg, 5);
        check("ab_c1_data", wr_data, 16'hAAAA);
        check("ab_c1_b_ready", b_ready, 0);
        step();
        check("ab_c2_en", wr_en, 1);
        check("ab_c2_reg", wr_reg, 6);
        check("ab_c2_data", wr_data, 16'h5555);
        step();
        check("ab_done", wr_en, 0);

        // Leave priority with B, then same-register collision must still go A first
        a_valid = 1; a_reg = 4'd1; a_data = 16'h0BAD;
        step(); idle_inputs();
        step();
        a_valid = 1; a_reg = 4'd7; a_data = 16'h0001;
        b_valid = 1; b_reg = 4'd7; b_data = 16'h0002;
        step(); idle_inputs();
        check("r7_first", wr_data, 16'h0001);
        check("r7_first_reg", wr_reg, 7);
        step();
        check("r7_second", wr_data, 16'h0002);
        step();
        check("r7_done", wr_en, 0);
        check("model_r7_final", m_rf[7], 16'h0002);

        // Pending tracking on r4
        rd_reg1 = 4'd4;
        alloc_valid = 1; alloc_reg = 4'd4;
        step(); idle_inputs();
        check("busy_after_alloc", rd_busy1, 1);
        a_valid = 1; a_reg = 4'd4; a_data = 16'h4444;
        step(); idle_inputs();
`ifndef WB_BYPASS_EN
        check("busy_commit_cycle", rd_busy1, 1);
`endif
        step();
        check("busy_cleared", rd_busy1, 0);
        alloc_valid = 1; alloc_reg = 4'd4;
        step(); idle_inputs();
        a_valid = 1; a_reg = 4'd4; a_data = 16'h4445;
        step(); idle_inputs();
        alloc_valid = 1; alloc_reg = 4'd4;
        step(); idle_inputs();
        check("busy_realloc_on_commit", rd_busy1, 1);

        // Request to r0 is dropped; alloc of r0 is ignored
        rd_reg2 = 4'd0;
        a_valid = 1; a_reg = 4'd0; a_data = 16'hFFFF;
        alloc_valid = 1; alloc_reg = 4'd0;
        step(); idle_inputs();
        check("r0_no_wr_en", wr_en, 0);
        check("r0_ready", a_ready, 1);
        check("r0_not_busy", rd_busy2, 0);
        step();
        check("r0_no_wr_en2", wr_en, 0);

        // Asynchronous reset with both slots full
        a_valid = 1; a_reg = 4'd9;  a_data = 16'h9999;
        b_valid = 1; b_reg = 4'd10; b_data = 16'hAAAA;
        step(); idle_inputs();
        #3 rst_n = 0;
        #1;
        check("async_rst_wr_en", wr_en, 0);
        check("async_rst_wr_reg", wr_reg, 0);
        check("async_rst_wr_data", wr_data, 0);
        check("async_rst_a_ready", a_ready, 0);
        check("async_rst_b_ready", b_ready, 0);
        check("async_rst_busy1", rd_busy1, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        check("rst_release_a_ready", a_ready, 1);
        check("rst_release_b_ready", b_ready, 1);
        check("rst_discard_wr_en", wr_en, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle_inputs();
                do_reset();
            end
            a_valid     = ($urandom_range(0, 3) != 0);
            b_valid     = ($urandom_range(0, 3) != 0);
            a_reg       = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
            b_reg       = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
            a_data      = DW'($urandom);
            b_data      = DW'($urandom);
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_reg   = AW'($urandom_range(0, 7));
            rd_reg1     = AW'($urandom_range(0, 7));
            rd_reg2     = AW'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
